// File: rtl/aes_pkg.sv
// Shared AES-128 types, sizes and the column-major byte map of a 128-bit block.
package aes_pkg;

  localparam int unsigned AES_NB         = 4;
  localparam int unsigned AES_BYTE_W     = 8;
  localparam int unsigned AES_WORD_W     = 32;
  localparam int unsigned AES_BLOCK_W    = 128;
  localparam int unsigned AES_STATE_BYTES = AES_NB * AES_NB;

  typedef logic [AES_BYTE_W-1:0]  aes_byte_t;
  typedef logic [AES_WORD_W-1:0]  aes_word_t;
  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  // Byte (4*col + row) of a block; byte 0 is the most significant byte.
  function automatic aes_byte_t get_text_byte(input aes_block_t block,
                                              input int unsigned row,
                                              input int unsigned col);
    int unsigned k;
    k = AES_NB * col + row;
    return aes_byte_t'(block >> (AES_BYTE_W * (AES_STATE_BYTES - 1 - k)));
  endfunction

  // Byte "row" of a key word; row 0 is the most significant byte.
  function automatic aes_byte_t get_word_byte(input aes_word_t word,
                                              input int unsigned row);
    return aes_byte_t'(word >> (AES_BYTE_W * (AES_NB - 1 - row)));
  endfunction

endpackage : aes_pkg

// File: rtl/aes_state_ark.sv
// AES-128 cipher state register with the initial AddRoundKey folded into the load.
// Ports:
//   clk, rst (async active-low)
//   ld_r                 load strobe: capture text_in_r ^ round-0 key
//   text_in_r            plaintext block, byte 0 in bits [127:120]
//   w0..w3               round-key words, one per state column
//   saRC_next            next-round state byte from the round logic
//   saRC                 registered state byte, row R column C
module aes_state_ark
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_r,
  input  aes_block_t text_in_r,
  input  aes_word_t  w0,
  input  aes_word_t  w1,
  input  aes_word_t  w2,
  input  aes_word_t  w3,
  input  aes_byte_t  sa00_next,
  input  aes_byte_t  sa01_next,
  input  aes_byte_t  sa02_next,
  input  aes_byte_t  sa03_next,
  input  aes_byte_t  sa10_next,
  input  aes_byte_t  sa11_next,
  input  aes_byte_t  sa12_next,
  input  aes_byte_t  sa13_next,
  input  aes_byte_t  sa20_next,
  input  aes_byte_t  sa21_next,
  input  aes_byte_t  sa22_next,
  input  aes_byte_t  sa23_next,
  input  aes_byte_t  sa30_next,
  input  aes_byte_t  sa31_next,
  input  aes_byte_t  sa32_next,
  input  aes_byte_t  sa33_next,
  output aes_byte_t  sa00,
  output aes_byte_t  sa01,
  output aes_byte_t  sa02,
  output aes_byte_t  sa03,
  output aes_byte_t  sa10,
  output aes_byte_t  sa11,
  output aes_byte_t  sa12,
  output aes_byte_t  sa13,
  output aes_byte_t  sa20,
  output aes_byte_t  sa21,
  output aes_byte_t  sa22,
  output aes_byte_t  sa23,
  output aes_byte_t  sa30,
  output aes_byte_t  sa31,
  output aes_byte_t  sa32,
  output aes_byte_t  sa33
);

  // Flat views indexed by column-major byte number 4*col + row.
  logic      [AES_STATE_BYTES-1:0][AES_BYTE_W-1:0] nxt_flat;
  logic      [AES_STATE_BYTES-1:0][AES_BYTE_W-1:0] st_flat;
  aes_word_t [AES_NB-1:0]                          wk;

  assign wk = {w3, w2, w1, w0};

  assign nxt_flat = {sa33_next, sa23_next, sa13_next, sa03_next,
                     sa32_next, sa22_next, sa12_next, sa02_next,
                     sa31_next, sa21_next, sa11_next, sa01_next,
                     sa30_next, sa20_next, sa10_next, sa00_next};

  assign {sa33, sa23, sa13, sa03,
          sa32, sa22, sa12, sa02,
          sa31, sa21, sa11, sa01,
          sa30, sa20, sa10, sa00} = st_flat;

  // One state byte flop per row/column; load wins over the round datapath.
  for (genvar c = 0; c < AES_NB; c++) begin : g_col
    for (genvar r = 0; r < AES_NB; r++) begin : g_row
      aes_byte_t q;
      aes_byte_t ark;

      assign ark = get_text_byte(text_in_r, r, c) ^ get_word_byte(wk[c], r);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          q <= '0;
        end else if (ld_r) begin
          q <= ark;
        end else begin
          q <= nxt_flat[AES_NB*c + r];
        end
      end

      assign st_flat[AES_NB*c + r] = q;
    end
  end

endmodule : aes_state_ark

// File: tb/tb_aes_state_ark.sv
// Directed bench for aes_state_ark: reset, FIPS-197 round-0 load, next-state path,
// load priority, mid-sequence reset and back-to-back loads.
module tb_aes_state_ark;

  logic              clk;
  logic              rst;
  logic              ld_r;
  logic [127:0]      text_in_r;
  logic [31:0]       w0, w1, w2, w3;
  logic [15:0][7:0]  nx;
  logic [15:0][7:0]  q;

  int tests;
  int fails;

  aes_state_ark dut (
    .clk(clk), .rst(rst), .ld_r(ld_r), .text_in_r(text_in_r),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .sa00_next(nx[0]),  .sa10_next(nx[1]),  .sa20_next(nx[2]),  .sa30_next(nx[3]),
    .sa01_next(nx[4]),  .sa11_next(nx[5]),  .sa21_next(nx[6]),  .sa31_next(nx[7]),
    .sa02_next(nx[8]),  .sa12_next(nx[9]),  .sa22_next(nx[10]), .sa32_next(nx[11]),
    .sa03_next(nx[12]), .sa13_next(nx[13]), .sa23_next(nx[14]), .sa33_next(nx[15]),
    .sa00(q[0]),  .sa10(q[1]),  .sa20(q[2]),  .sa30(q[3]),
    .sa01(q[4]),  .sa11(q[5]),  .sa21(q[6]),  .sa31(q[7]),
    .sa02(q[8]),  .sa12(q[9]),  .sa22(q[10]), .sa32(q[11]),
    .sa03(q[12]), .sa13(q[13]), .sa23(q[14]), .sa33(q[15])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // State as a 128-bit block, byte 0 (sa00) in the top byte.
  function automatic logic [127:0] state_cm();
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v = {v[119:0], q[k]};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nx_all(input logic [7:0] b);
    for (int k = 0; k < 16; k++) nx[k] = b;
  endtask

  task automatic load_fips();
    ld_r      = 1'b1;
    text_in_r = 128'h00112233445566778899aabbccddeeff;
    w0 = 32'h00010203; w1 = 32'h04050607; w2 = 32'h08090a0b; w3 = 32'h0c0d0e0f;
  endtask

  localparam logic [127:0] FIPS_ARK = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] RC_PAT   = 128'h00102030011121310212223203132333;

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; ld_r = 1'b0; text_in_r = '0;
    w0 = '0; w1 = '0; w2 = '0; w3 = '0;
    set_nx_all(8'hFF);

    // Next-state path fills the state with FF before any reset.
    tick(); tick();
    chk("pre_reset_next", state_cm(), {16{8'hFF}});

    // Async reset between edges clears immediately.
    #3 rst = 1'b0;
    #1 chk("async_reset_now", state_cm(), '0);
    tick();
    chk("reset_held_edge", state_cm(), '0);
    #3 rst = 1'b1;

    // FIPS-197 round-0 AddRoundKey.
    load_fips();
    tick();
    chk("fips_ark", state_cm(), FIPS_ARK);
    chk("fips_sa33", 128'(q[15]), 128'h0f0);
    chk("fips_sa01", 128'(q[4]), 128'h040);

    // Outputs are flop outputs: changing inputs between edges has no effect.
    text_in_r = '1; w0 = '1;
    #2 chk("no_comb_path", state_cm(), FIPS_ARK);

    // Next-state path: byte rc gets {r,c}.
    ld_r = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        nx[4*c + r] = 8'((r << 4) | c);
    tick();
    chk("next_sa12", 128'(q[9]), 128'h012);
    chk("next_all", state_cm(), RC_PAT);

    // Load beats next-state.
    ld_r = 1'b1; set_nx_all(8'hAA); text_in_r = '0;
    w0 = 32'h5A5A5A5A; w1 = 32'h5A5A5A5A; w2 = 32'h5A5A5A5A; w3 = 32'h5A5A5A5A;
    tick();
    chk("load_priority", state_cm(), {16{8'h5A}});

    // Mid-sequence reset.
    load_fips();
    tick();
    chk("reload_fips", state_cm(), FIPS_ARK);
    ld_r = 1'b0;
    set_nx_all(8'h11); tick(); chk("run_c1", state_cm(), {16{8'h11}});
    set_nx_all(8'h22); tick(); chk("run_c2", state_cm(), {16{8'h22}});
    set_nx_all(8'h33); tick(); chk("run_c3", state_cm(), {16{8'h33}});
    set_nx_all(8'hC3);
    #2 rst = 1'b0;
    #1 chk("mid_reset_now", state_cm(), '0);
    #2 rst = 1'b1;
    #1 chk("mid_reset_released", state_cm(), '0);
    tick();
    chk("post_release_next", state_cm(), {16{8'hC3}});

    // Back-to-back loads.
    ld_r = 1'b1; text_in_r = '0;
    w0 = '0; w1 = '0; w2 = '0; w3 = '0;
    tick();
    chk("b2b_load0", state_cm(), '0);
    text_in_r = '1;
    tick();
    chk("b2b_load1", state_cm(), {16{8'hFF}});
    ld_r = 1'b0; set_nx_all(8'h3C);
    tick();
    chk("after_b2b_next", state_cm(), {16{8'h3C}});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_aes_state_ark
